// File: rtl/iommu_walker_arbiter.sv
// Round-robin arbiter sharing one AXI read master between the two IOMMU page-table walkers.
// Optional perf counters are enabled by defining IOMMU_WALKER_ARB_PERF_EN.
module iommu_walker_arbiter #(
  parameter int unsigned ADDR_W = 34,
  parameter int unsigned DATA_W = 256,
  parameter int unsigned ID_W   = 3
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic [ADDR_W-1:0] s0_araddr,
  input  logic [7:0]        s0_arlen,
  input  logic [2:0]        s0_arsize,
  input  logic [1:0]        s0_arburst,
  input  logic [2:0]        s0_arprot,
  input  logic [ID_W-1:0]   s0_arid,
  input  logic              s0_arvalid,
  output logic              s0_arready,
  output logic [DATA_W-1:0] s0_rdata,
  output logic [1:0]        s0_rresp,
  output logic              s0_rlast,
  output logic [ID_W-1:0]   s0_rid,
  output logic              s0_rvalid,
  input  logic              s0_rready,
  input  logic [ADDR_W-1:0] s1_araddr,
  input  logic [7:0]        s1_arlen,
  input  logic [2:0]        s1_arsize,
  input  logic [1:0]        s1_arburst,
  input  logic [2:0]        s1_arprot,
  input  logic [ID_W-1:0]   s1_arid,
  input  logic              s1_arvalid,
  output logic              s1_arready,
  output logic [DATA_W-1:0] s1_rdata,
  output logic [1:0]        s1_rresp,
  output logic              s1_rlast,
  output logic [ID_W-1:0]   s1_rid,
  output logic              s1_rvalid,
  input  logic              s1_rready,
  output logic [ADDR_W-1:0] m_araddr,
  output logic [7:0]        m_arlen,
  output logic [2:0]        m_arsize,
  output logic [1:0]        m_arburst,
  output logic [2:0]        m_arprot,
  output logic [ID_W-1:0]   m_arid,
  output logic              m_arvalid,
  input  logic              m_arready,
  input  logic [DATA_W-1:0] m_rdata,
  input  logic [1:0]        m_rresp,
  input  logic              m_rlast,
  input  logic [ID_W-1:0]   m_rid,
  input  logic              m_rvalid,
  output logic              m_rready,
  output logic              busy,
  output logic              grant
`ifdef IOMMU_WALKER_ARB_PERF_EN
  ,
  input  logic              perf_clr,
  output logic [31:0]       perf_grant0,
  output logic [31:0]       perf_grant1,
  output logic [31:0]       perf_wait
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    DATA = 2'b10
  } state_t;

  state_t state, state_nxt;
  logic ptr, sel, any_req, ar_hs, r_done;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_len;
  logic [2:0]        sel_size;
  logic [1:0]        sel_burst;
  logic [2:0]        sel_prot;
  logic [ID_W-1:0]   sel_id;

  assign any_req    = s0_arvalid | s1_arvalid;
  assign sel        = (s0_arvalid && s1_arvalid) ? ptr : s1_arvalid;
  assign ar_hs      = (state == IDLE) && any_req;
  assign r_done     = (state == DATA) && m_rvalid && m_rready && m_rlast;
  assign s0_arready = ar_hs && !sel;
  assign s1_arready = ar_hs && sel;
  assign busy       = (state != IDLE);

  always_comb begin
    if (sel) begin
      sel_addr  = s1_araddr;
      sel_len   = s1_arlen;
      sel_size  = s1_arsize;
      sel_burst = s1_arburst;
      sel_prot  = s1_arprot;
      sel_id    = s1_arid;
    end else begin
      sel_addr  = s0_araddr;
      sel_len   = s0_arlen;
      sel_size  = s0_arsize;
      sel_burst = s0_arburst;
      sel_prot  = s0_arprot;
      sel_id    = s0_arid;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ADDR;
      ADDR:    if (m_arvalid && m_arready) state_nxt = DATA;
      DATA:    if (r_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_araddr  <= '0;
      m_arlen   <= '0;
      m_arsize  <= '0;
      m_arburst <= '0;
      m_arprot  <= '0;
      m_arid    <= '0;
      m_arvalid <= 1'b0;
      grant     <= 1'b0;
      ptr       <= 1'b0;
    end else begin
      if (ar_hs) begin
        m_araddr  <= sel_addr;
        m_arlen   <= sel_len;
        m_arsize  <= sel_size;
        m_arburst <= sel_burst;
        m_arprot  <= sel_prot;
        m_arid    <= sel_id;
        m_arvalid <= 1'b1;
        grant     <= sel;
      end else if ((state == ADDR) && m_arready) begin
        m_arvalid <= 1'b0;
      end
      if (r_done) ptr <= ~grant;
    end
  end

  // R channel is a pure wire path to the granted walker; no beat buffering.
  always_comb begin
    s0_rdata  = '0;
    s0_rresp  = '0;
    s0_rlast  = 1'b0;
    s0_rid    = '0;
    s0_rvalid = 1'b0;
    s1_rdata  = '0;
    s1_rresp  = '0;
    s1_rlast  = 1'b0;
    s1_rid    = '0;
    s1_rvalid = 1'b0;
    m_rready  = 1'b0;
    if (state == DATA) begin
      if (grant) begin
        s1_rdata  = m_rdata;
        s1_rresp  = m_rresp;
        s1_rlast  = m_rlast;
        s1_rid    = m_rid;
        s1_rvalid = m_rvalid;
        m_rready  = s1_rready;
      end else begin
        s0_rdata  = m_rdata;
        s0_rresp  = m_rresp;
        s0_rlast  = m_rlast;
        s0_rid    = m_rid;
        s0_rvalid = m_rvalid;
        m_rready  = s0_rready;
      end
    end
  end

`ifdef IOMMU_WALKER_ARB_PERF_EN
  logic wait_pend;

  // In IDLE the loser of a contested cycle is the waiter; in ADDR it is the non-granted walker.
  always_comb begin
    wait_pend = 1'b0;
    case (state)
      IDLE:    wait_pend = s0_arvalid && s1_arvalid;
      ADDR:    wait_pend = grant ? s0_arvalid : s1_arvalid;
      default: wait_pend = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_wait   <= '0;
    end else if (perf_clr) begin
      perf_grant0 <= '0;
      perf_grant1 <= '0;
      perf_wait   <= '0;
    end else begin
      if (r_done && !grant && (perf_grant0 != '1)) perf_grant0 <= perf_grant0 + 32'd1;
      if (r_done && grant && (perf_grant1 != '1))  perf_grant1 <= perf_grant1 + 32'd1;
      if (wait_pend && (perf_wait != '1))          perf_wait   <= perf_wait + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_iommu_walker_arbiter.sv
// Scoreboard bench for iommu_walker_arbiter: random walker traffic, a reactive memory model,
// and monitors that pop expected AR requests and R beats as the DUT presents them.
`timescale 1ns/1ps
module tb_iommu_walker_arbiter;
  localparam int unsigned ADDR_W = 34;
  localparam int unsigned DATA_W = 256;
  localparam int unsigned ID_W   = 3;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] s0_araddr, s1_araddr, m_araddr;
  logic [7:0]        s0_arlen, s1_arlen, m_arlen;
  logic [2:0]        s0_arsize, s1_arsize, m_arsize;
  logic [1:0]        s0_arburst, s1_arburst, m_arburst;
  logic [2:0]        s0_arprot, s1_arprot, m_arprot;
  logic [ID_W-1:0]   s0_arid, s1_arid, m_arid;
  logic              s0_arvalid, s1_arvalid, m_arvalid;
  logic              s0_arready, s1_arready, m_arready;
  logic [DATA_W-1:0] s0_rdata, s1_rdata, m_rdata;
  logic [1:0]        s0_rresp, s1_rresp, m_rresp;
  logic              s0_rlast, s1_rlast, m_rlast;
  logic [ID_W-1:0]   s0_rid, s1_rid, m_rid;
  logic              s0_rvalid, s1_rvalid, m_rvalid;
  logic              s0_rready, s1_rready, m_rready;
  logic              busy, grant;
`ifdef IOMMU_WALKER_ARB_PERF_EN
  logic              perf_clr;
  logic [31:0]       perf_grant0, perf_grant1, perf_wait;
`endif

  iommu_walker_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .resetn(resetn),
    .s0_araddr(s0_araddr), .s0_arlen(s0_arlen), .s0_arsize(s0_arsize), .s0_arburst(s0_arburst),
    .s0_arprot(s0_arprot), .s0_arid(s0_arid), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
    .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rlast(s0_rlast), .s0_rid(s0_rid),
    .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
    .s1_araddr(s1_araddr), .s1_arlen(s1_arlen), .s1_arsize(s1_arsize), .s1_arburst(s1_arburst),
    .s1_arprot(s1_arprot), .s1_arid(s1_arid), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
    .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rlast(s1_rlast), .s1_rid(s1_rid),
    .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
    .m_araddr(m_araddr), .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
    .m_arprot(m_arprot), .m_arid(m_arid), .m_arvalid(m_arvalid), .m_arready(m_arready),
    .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rlast(m_rlast), .m_rid(m_rid),
    .m_rvalid(m_rvalid), .m_rready(m_rready),
    .busy(busy), .grant(grant)
`ifdef IOMMU_WALKER_ARB_PERF_EN
    , .perf_clr(perf_clr), .perf_grant0(perf_grant0), .perf_grant1(perf_grant1), .perf_wait(perf_wait)
`endif
  );

  typedef struct {
    int                who;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        len;
    logic [2:0]        size;
    logic [1:0]        burst;
    logic [2:0]        prot;
    logic [ID_W-1:0]   id;
  } req_t;

  typedef struct {
    int                who;
    logic [DATA_W-1:0] data;
    logic [1:0]        resp;
    logic              last;
    logic [ID_W-1:0]   id;
  } beat_t;

  req_t  ar_q[$];
  beat_t beat_q[$];
  int total = 0;
  int bad = 0;
  int ptr_m = 0;
  int cnt0 = 0;
  int cnt1 = 0;
  int beats_seen = 0;
  int ar_stall = 0;
  logic arv_expect = 1'b0;

  task automatic chk(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    total++;
    bad++;
    $display("FAIL %s act=present exp=absent", name);
  endtask

  // Memory content is a fixed function of address and beat number.
  function automatic logic [DATA_W-1:0] mem_data(input logic [ADDR_W-1:0] a, input int b);
    logic [DATA_W-1:0] d;
    for (int i = 0; i < 8; i++)
      d[i*32 +: 32] = a[31:0] ^ 32'(a >> 32) ^ (32'h9E37_79B9 * 32'(b * 8 + i + 1));
    return d;
  endfunction

  function automatic logic [1:0] mem_resp(input logic [ADDR_W-1:0] a, input int b);
    return 2'(a[7:6] + 2'(b));
  endfunction

  function automatic req_t mk_req(input int who);
    req_t r;
    r.who   = who;
    r.addr  = ADDR_W'({$urandom(), $urandom()});
    r.len   = ($urandom_range(3) == 0) ? 8'($urandom_range(7)) : 8'($urandom_range(1));
    r.size  = 3'($urandom_range(7));
    r.burst = 2'($urandom_range(3));
    r.prot  = 3'($urandom_range(7));
    r.id    = ID_W'($urandom_range(7));
    return r;
  endfunction

  task automatic push_txn(input req_t r);
    beat_t b;
    ar_q.push_back(r);
    for (int i = 0; i <= int'(r.len); i++) begin
      b.who  = r.who;
      b.data = mem_data(r.addr, i);
      b.resp = mem_resp(r.addr, i);
      b.last = (i == int'(r.len));
      b.id   = r.id;
      beat_q.push_back(b);
    end
    if (r.who == 0) cnt0++;
    else            cnt1++;
  endtask

  task automatic set_ar(input req_t r, input logic v);
    if (r.who == 0) begin
      s0_araddr = r.addr; s0_arlen = r.len; s0_arsize = r.size;
      s0_arburst = r.burst; s0_arprot = r.prot; s0_arid = r.id; s0_arvalid = v;
    end else begin
      s1_araddr = r.addr; s1_arlen = r.len; s1_arsize = r.size;
      s1_arburst = r.burst; s1_arprot = r.prot; s1_arid = r.id; s1_arvalid = v;
    end
  endtask

  task automatic drive(input req_t r);
    logic done;
    done = 1'b0;
    set_ar(r, 1'b1);
    for (int c = 0; c < 400 && !done; c++) begin
      @(negedge clk);
      if ((r.who == 0) ? s0_arready : s1_arready) done = 1'b1;
    end
    chk("ar_accept", done, 1);
    @(posedge clk);
    #1;
    set_ar(r, 1'b0);
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((ar_q.size() != 0 || beat_q.size() != 0 || busy) && c < 2000) begin
      @(negedge clk);
      c++;
    end
    chk("round_drain", (c < 2000), 1);
  endtask

  // Reference arbitration: a contested round serves the preferred walker first; the walker
  // that completed last becomes the non-preferred one.
  task automatic run_round(input int pat, input req_t r0, input req_t r1);
    if (pat == 3) begin
      if (ptr_m == 0) begin push_txn(r0); push_txn(r1); end
      else            begin push_txn(r1); push_txn(r0); end
    end else if (pat == 1) begin
      push_txn(r0);
      ptr_m = 1;
    end else begin
      push_txn(r1);
      ptr_m = 0;
    end
    @(posedge clk);
    #1;
    fork
      begin if (pat[0]) drive(r0); end
      begin if (pat[1]) drive(r1); end
    join
    wait_idle();
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_m_arvalid"}, m_arvalid, 0);
    chk({tag, "_m_rready"}, m_rready, 0);
    chk({tag, "_s0_rvalid"}, s0_rvalid, 0);
    chk({tag, "_s1_rvalid"}, s1_rvalid, 0);
    chk({tag, "_grant"}, grant, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_m_araddr"}, m_araddr, 0);
    chk({tag, "_m_arid"}, m_arid, 0);
  endtask

  initial begin : walker_rready
    s0_rready = 1'b0;
    s1_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      s0_rready = ($urandom_range(3) != 0);
      s1_rready = ($urandom_range(3) != 0);
    end
  end

  initial begin : mem_model
    logic ar_hs_s, r_hs_s, mbusy, real_up;
    logic [ADDR_W-1:0] maddr;
    logic [7:0]        mlen;
    logic [ID_W-1:0]   mid;
    int beat;
    m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = '0; m_rresp = '0; m_rlast = 1'b0; m_rid = '0;
    mbusy = 1'b0; real_up = 1'b0; beat = 0; maddr = '0; mlen = '0; mid = '0;
    forever begin
      @(negedge clk);
      ar_hs_s = m_arvalid && m_arready;
      r_hs_s  = m_rvalid && m_rready;
      if (ar_hs_s) begin maddr = m_araddr; mlen = m_arlen; mid = m_arid; end
      @(posedge clk);
      #1;
      if (!resetn) begin
        mbusy = 1'b0; real_up = 1'b0; m_rvalid = 1'b0; m_rlast = 1'b0; m_arready = 1'b0;
      end else begin
        if (mbusy && r_hs_s) begin
          if (m_rlast) mbusy = 1'b0;
          else         beat++;
          real_up = 1'b0;
        end
        if (ar_hs_s) begin mbusy = 1'b1; beat = 0; real_up = 1'b0; end
        if (mbusy) begin
          if (!real_up) begin
            if ($urandom_range(3) != 0) begin
              m_rvalid = 1'b1;
              m_rdata  = mem_data(maddr, beat);
              m_rresp  = mem_resp(maddr, beat);
              m_rlast  = (beat == int'(mlen));
              m_rid    = mid;
              real_up  = 1'b1;
            end else begin
              m_rvalid = 1'b0;
            end
          end
        end else begin
          real_up = 1'b0;
          // Occasional stray beat while nothing is outstanding; it must be ignored.
          if ($urandom_range(7) == 0) begin
            m_rvalid = 1'b1; m_rlast = 1'b1; m_rdata = {8{32'hDEAD_BEEF}}; m_rid = '1; m_rresp = 2'b11;
          end else begin
            m_rvalid = 1'b0;
          end
        end
        if (ar_stall > 0) begin
          m_arready = 1'b0;
          ar_stall--;
        end else begin
          m_arready = ($urandom_range(2) != 0);
        end
      end
    end
  end

  initial begin : ar_mon
    req_t e;
    forever begin
      @(negedge clk);
      if (resetn) begin
        if (arv_expect) begin
          chk("ar_latency", m_arvalid, 1);
          chk("busy_after_ar", busy, 1);
          arv_expect = 1'b0;
        end
        if ((s0_arvalid && s0_arready) || (s1_arvalid && s1_arready)) arv_expect = 1'b1;
        if (m_arvalid) begin
          if (ar_q.size() == 0) begin
            fail("ar_unexpected");
          end else begin
            e = ar_q[0];
            chk("m_araddr", m_araddr, e.addr);
            chk("m_arlen", m_arlen, e.len);
            chk("m_arsize", m_arsize, e.size);
            chk("m_arburst", m_arburst, e.burst);
            chk("m_arprot", m_arprot, e.prot);
            chk("m_arid", m_arid, e.id);
            chk("grant", grant, e.who);
            if (m_arready) e = ar_q.pop_front();
          end
        end
      end else begin
        arv_expect = 1'b0;
      end
    end
  end

  initial begin : r_mon
    beat_t b;
    logic rv, rr;
    logic [DATA_W-1:0] rd;
    logic [1:0] rs;
    logic rl;
    logic [ID_W-1:0] ri;
    forever begin
      @(negedge clk);
      if (resetn) begin
        chk("arready_excl", s0_arready && s1_arready, 0);
        chk("arready_idle", busy && (s0_arready || s1_arready), 0);
        chk("rvalid_excl", s0_rvalid && s1_rvalid, 0);
        chk("r_quiet", (!busy || m_arvalid) && (m_rready || s0_rvalid || s1_rvalid), 0);
        if (busy && !m_arvalid && beat_q.size() > 0) begin
          chk("m_rready_route", m_rready, (beat_q[0].who != 0) ? s1_rready : s0_rready);
          chk("rvalid_route", (beat_q[0].who != 0) ? s1_rvalid : s0_rvalid, m_rvalid);
        end
        for (int n = 0; n < 2; n++) begin
          rv = (n != 0) ? s1_rvalid : s0_rvalid;
          rr = (n != 0) ? s1_rready : s0_rready;
          rd = (n != 0) ? s1_rdata : s0_rdata;
          rs = (n != 0) ? s1_rresp : s0_rresp;
          rl = (n != 0) ? s1_rlast : s0_rlast;
          ri = (n != 0) ? s1_rid : s0_rid;
          if (rv && rr) begin
            if (beat_q.size() == 0) begin
              fail("r_unexpected");
            end else begin
              b = beat_q.pop_front();
              chk("r_who", n, b.who);
              chk("rdata", rd, b.data);
              chk("rresp", rs, b.resp);
              chk("rlast", rl, b.last);
              chk("rid", ri, b.id);
              beats_seen++;
            end
          end
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin : main
    req_t r0, r1;
    int c, base, pat;
    s0_araddr = '0; s0_arlen = '0; s0_arsize = '0; s0_arburst = '0; s0_arprot = '0; s0_arid = '0; s0_arvalid = 1'b0;
    s1_araddr = '0; s1_arlen = '0; s1_arsize = '0; s1_arburst = '0; s1_arprot = '0; s1_arid = '0; s1_arvalid = 1'b0;
`ifdef IOMMU_WALKER_ARB_PERF_EN
    perf_clr = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    check_reset("por");
    resetn = 1'b1;

    // Contested pairs straight out of reset: expected grants 0,1,0,1,...
    for (int i = 0; i < 4; i++) begin
      r0 = mk_req(0);
      r1 = mk_req(1);
      run_round(3, r0, r1);
    end

    r0 = mk_req(0);
    r0.addr = 34'h0_1000_0040;
    r0.len  = 8'd0;
    run_round(1, r0, r1);

    // s1 preferred next: its 4-beat burst runs under an AR stall while s0 waits.
    r0 = mk_req(0);
    r1 = mk_req(1);
    r1.len = 8'd3;
    ar_stall = 7;
    run_round(3, r0, r1);

    for (int i = 0; i < 40; i++) begin
      pat = int'($urandom_range(3, 1));
      r0 = mk_req(0);
      r1 = mk_req(1);
      run_round(pat, r0, r1);
    end

    // Reset during a burst, after its first beat.
    r1 = mk_req(1);
    r1.len = 8'd3;
    push_txn(r1);
    @(posedge clk);
    #1;
    base = beats_seen;
    drive(r1);
    c = 0;
    while (beats_seen == base && c < 500) begin
      @(negedge clk);
      c++;
    end
    chk("burst_first_beat", (beats_seen > base), 1);
    @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check_reset("mid");
    ar_q.delete();
    beat_q.delete();
    ptr_m = 0;
    cnt0 = 0;
    cnt1 = 0;
    repeat (3) @(posedge clk);
    #1;
    resetn = 1'b1;
    r1 = mk_req(1);
    run_round(2, r0, r1);
    for (int i = 0; i < 6; i++) begin
      r0 = mk_req(0);
      r1 = mk_req(1);
      run_round((i < 3) ? 1 : ((i == 3) ? 3 : 2), r0, r1);
    end

`ifdef IOMMU_WALKER_ARB_PERF_EN
    @(negedge clk);
    chk("perf_grant0", perf_grant0, cnt0);
    chk("perf_grant1", perf_grant1, cnt1);
    @(posedge clk);
    #1;
    perf_clr = 1'b1;
    @(posedge clk);
    #1;
    perf_clr = 1'b0;
    @(negedge clk);
    chk("perf_grant0_clr", perf_grant0, 0);
    chk("perf_grant1_clr", perf_grant1, 0);
    chk("perf_wait_clr", perf_wait, 0);
`endif

    repeat (2) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iommu_walker_arbiter.md
Name: iommu_walker_arbiter

Overview:
- Shares one AXI read master port to memory between the two IOMMU page-table walkers: the read-channel walker (requester 0) and the write-channel walker (requester 1).
- Sits between the walker AR/R ports and the memory interconnect, replacing two separate walker masters with one.
- Allows one outstanding transaction at a time, with round-robin arbitration and R-channel routing back to the granted walker.

Parameters:
- ADDR_W, 34, AR address width on all ports
- DATA_W, 256, R data width on all ports
- ID_W, 3, AR/R ID width on all ports

Ports:
- clk  in  1  block clock; all logic rising-edge
- resetn  in  1  asynchronous active-low reset
- sN_araddr  in  ADDR_W  walker N read address (N = 0, 1; every sN_ port is present once per walker)
- sN_arlen  in  8  walker N burst length
- sN_arsize  in  3  walker N beat size
- sN_arburst  in  2  walker N burst type
- sN_arprot  in  3  walker N protection
- sN_arid  in  ID_W  walker N ID
- sN_arvalid  in  1  walker N request valid
- sN_arready  out  1  walker N request accepted
- sN_rdata  out  DATA_W  read data to walker N
- sN_rresp  out  2  read response to walker N
- sN_rlast  out  1  last beat to walker N
- sN_rid  out  ID_W  read ID to walker N
- sN_rvalid  out  1  read beat valid to walker N
- sN_rready  in  1  walker N accepts beat
- m_araddr/m_arlen/m_arsize/m_arburst/m_arprot/m_arid  out  (widths as sN_)  registered AR fields to memory
- m_arvalid  out  1  AR valid to memory
- m_arready  in  1  memory accepts AR
- m_rdata/m_rresp/m_rlast/m_rid  in  (widths as sN_)  read beat from memory
- m_rvalid  in  1  memory beat valid
- m_rready  out  1  accept memory beat
- busy  out  1  high whenever state != IDLE
- grant  out  1  index of the current/last granted requester

Behaviour:
- Clock and reset: single clock `clk`; reset `resetn` is asynchronous, active-low.
- Reset values:
  - State IDLE; m_arvalid=0; all m_ar* fields 0.
  - sN_rvalid=0, m_rready=0, busy=0.
  - grant=0; priority pointer=0, so requester 0 is preferred first.
- States:
  - IDLE → ADDR → DATA → IDLE.
  - Encoded in 2 bits; unused encoding returns to IDLE.
- IDLE:
  - sel is combinational. If only one sN_arvalid is high, sel = that N. If both are high, sel = priority pointer.
  - sN_arready = (state==IDLE) && any arvalid && (sel==N), combinational. Never high for both requesters, never high outside IDLE.
  - On the handshake: register the selected AR fields into m_ar*, set grant=sel, m_arvalid<=1, go to ADDR.
  - Latency: AR accepted in cycle T → m_arvalid=1 in cycle T+1.
- ADDR:
  - m_arvalid and all m_ar* fields are held stable until m_arready.
  - On m_arvalid && m_arready: m_arvalid<=0, go to DATA.
- DATA:
  - Combinational pass-through to the granted walker: s{grant}_r* = m_r*, s{grant}_rvalid = m_rvalid, m_rready = s{grant}_rready.
  - The non-granted walker sees sN_rvalid=0.
  - Multi-beat bursts are passed beat by beat. Back-pressure from the walker stalls memory with no buffering.
  - On m_rvalid && m_rready && m_rlast: go to IDLE; pointer <= ~grant.
  - m_rid is forwarded unmodified and is not checked against m_arid.
- Outside DATA: m_rready=0 and both sN_rvalid=0. A stray m_rvalid is ignored, not accepted.
- Fairness: with both walkers continuously requesting, grants strictly alternate 0,1,0,1…
- Throughput: minimum 3 cycles per single-beat transaction; back-to-back requests need one IDLE cycle between them.
- Reset mid-operation: asserting resetn low in any state immediately returns all outputs to reset values. An in-flight burst is abandoned and the system must reset memory too.
- rresp (SLVERR/DECERR) is passed through unmodified. The arbiter takes no action on errors.

Optional Feature:
- Macro: IOMMU_WALKER_ARB_PERF_EN.
- When defined, the block adds:
  - Outputs perf_grant0 and perf_grant1, each 32 bits: count completed grants per requester, incremented on the final R handshake.
  - Output perf_wait, 32 bits: counts cycles in IDLE/ADDR with a non-granted arvalid pending.
  - Input perf_clr (1 bit): synchronous clear of all three counters.
  - Counters saturate at 0xFFFF_FFFF and reset to 0.
- When undefined: no counter logic and none of these ports exist; all other behaviour is identical.

Test Plan:
- Single request: s0 araddr=0x0_1000_0040, arlen=0; m_arready tied 1; one beat rdata=0xA5…A5 with rlast → m_araddr=0x0_1000_0040 one cycle after s0 handshake; s0_rvalid with 0xA5…A5; s1_rvalid stays 0; busy drops after the beat.
- Simultaneous requests straight after reset: s0 and s1 both valid → s0 granted first (grant=0), s1 granted next (grant=1); 4 back-to-back pairs give grant sequence 0,1,0,1,0,1,0,1.
- Back-pressure: m_arready held low 5 cycles → m_ar* fields stable across all 5 cycles. Then s1_rready low 3 cycles during a beat → m_rready low for those cycles; data delivered once.
- Burst: s1 arlen=3 → exactly 4 beats routed to s1; return to IDLE only after the beat with rlast; s0 request pending meanwhile is not accepted until then.
- Reset mid-burst: resetn low during DATA after beat 1 → m_arvalid=0, m_rready=0, sN_rvalid=0, grant=0 immediately; after release the next request from s1 alone is granted normally.
- With IOMMU_WALKER_ARB_PERF_EN defined: 3 s0 and 2 s1 transactions → perf_grant0=3, perf_grant1=2; perf_clr pulse → all counters 0.
